// File: rtl/decode_queue.sv
// decode_queue: registered RV32I decode stage.
// Raw instructions are decoded combinationally on accept and the decoded
// micro-ops are held in a small FIFO that dispatch drains with valid/ready.

`ifndef OpcodeLength
`define OpcodeLength 5
`define NOP   6'd0
`define LUI   6'd1
`define AUIPC 6'd2
`define JAL   6'd3
`define JALR  6'd4
`define BEQ   6'd5
`define BNE   6'd6
`define BLT   6'd7
`define BGE   6'd8
`define BLTU  6'd9
`define BGEU  6'd10
`define LB    6'd11
`define LH    6'd12
`define LW    6'd13
`define LBU   6'd14
`define LHU   6'd15
`define SB    6'd16
`define SH    6'd17
`define SW    6'd18
`define ADDI  6'd19
`define SLTI  6'd20
`define SLTIU 6'd21
`define XORI  6'd22
`define ORI   6'd23
`define ANDI  6'd24
`define SLLI  6'd25
`define SRLI  6'd26
`define SRAI  6'd27
`define ADD   6'd28
`define SUB   6'd29
`define SLL   6'd30
`define SLT   6'd31
`define SLTU  6'd32
`define XOR   6'd33
`define SRL   6'd34
`define SRA   6'd35
`define OR    6'd36
`define AND   6'd37
`endif

module decode_queue #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int REG_W = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PC_W-1:0]           in_pc,
    input  logic [31:0]               in_instr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PC_W-1:0]           out_pc,
    output logic [`OpcodeLength:0]    out_op,
    output logic [REG_W-1:0]          out_rd,
    output logic [REG_W-1:0]          out_rs1,
    output logic [REG_W-1:0]          out_rs2,
    output logic [XLEN-1:0]           out_imm,
    output logic                      out_use_rs1,
    output logic                      out_use_rs2,
    output logic                      out_is_sl,
    output logic                      out_is_br,
    output logic                      out_illegal
);

    localparam int OP_W  = `OpcodeLength + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [XLEN-1:0]  imm;
        logic             use_rs1;
        logic             use_rs2;
        logic             is_sl;
        logic             is_br;
        logic             illegal;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    entry_t           dec;
    entry_t           head_e;
    logic             legal;
    logic             accept;
    logic             pop;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [REG_W-1:0] rd_f, rs1_f, rs2_f;
    logic [XLEN-1:0]  imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign rd_f   = REG_W'(in_instr[11:7]);
    assign rs1_f  = REG_W'(in_instr[19:15]);
    assign rs2_f  = REG_W'(in_instr[24:20]);

    assign imm_i  = XLEN'($signed(in_instr[31:20]));
    assign imm_s  = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b  = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                   in_instr[11:8], 1'b0}));
    assign imm_j  = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                   in_instr[30:21], 1'b0}));
    assign imm_u  = XLEN'({in_instr[31:12], 12'b0});
    assign imm_sh = XLEN'(in_instr[24:20]);

    // Decode the offered instruction; anything undecodable collapses to a bare illegal marker.
    always_comb begin
        dec    = '0;
        dec.pc = in_pc;
        legal  = 1'b1;
        case (opcode)
            OPC_LUI: begin
                dec.op  = `LUI;
                dec.rd  = rd_f;
                dec.imm = imm_u;
            end
            OPC_AUIPC: begin
                dec.op  = `AUIPC;
                dec.rd  = rd_f;
                dec.imm = imm_u;
            end
            OPC_JAL: begin
                dec.op    = `JAL;
                dec.rd    = rd_f;
                dec.imm   = imm_j;
                dec.is_br = 1'b1;
            end
            OPC_JALR: begin
                dec.op      = `JALR;
                dec.rd      = rd_f;
                dec.rs1     = rs1_f;
                dec.use_rs1 = 1'b1;
                dec.imm     = imm_i;
                dec.is_br   = 1'b1;
                if (funct3 != 3'b000) legal = 1'b0;
            end
            OPC_BRANCH: begin
                dec.rs1     = rs1_f;
                dec.rs2     = rs2_f;
                dec.use_rs1 = 1'b1;
                dec.use_rs2 = 1'b1;
                dec.imm     = imm_b;
                dec.is_br   = 1'b1;
                case (funct3)
                    3'b000:  dec.op = `BEQ;
                    3'b001:  dec.op = `BNE;
                    3'b100:  dec.op = `BLT;
                    3'b101:  dec.op = `BGE;
                    3'b110:  dec.op = `BLTU;
                    3'b111:  dec.op = `BGEU;
                    default: legal  = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec.rd      = rd_f;
                dec.rs1     = rs1_f;
                dec.use_rs1 = 1'b1;
                dec.imm     = imm_i;
                dec.is_sl   = 1'b1;
                case (funct3)
                    3'b000:  dec.op = `LB;
                    3'b001:  dec.op = `LH;
                    3'b010:  dec.op = `LW;
                    3'b100:  dec.op = `LBU;
                    3'b101:  dec.op = `LHU;
                    default: legal  = 1'b0;
                endcase
            end
            OPC_STORE: begin
                dec.rs1     = rs1_f;
                dec.rs2     = rs2_f;
                dec.use_rs1 = 1'b1;
                dec.use_rs2 = 1'b1;
                dec.imm     = imm_s;
                dec.is_sl   = 1'b1;
                case (funct3)
                    3'b000:  dec.op = `SB;
                    3'b001:  dec.op = `SH;
                    3'b010:  dec.op = `SW;
                    default: legal  = 1'b0;
                endcase
            end
            OPC_OPIMM: begin
                dec.rd      = rd_f;
                dec.rs1     = rs1_f;
                dec.use_rs1 = 1'b1;
                dec.imm     = imm_i;
                case (funct3)
                    3'b000: dec.op = `ADDI;
                    3'b010: dec.op = `SLTI;
                    3'b011: dec.op = `SLTIU;
                    3'b100: dec.op = `XORI;
                    3'b110: dec.op = `ORI;
                    3'b111: dec.op = `ANDI;
                    3'b001: begin
                        dec.imm = imm_sh;
                        dec.op  = `SLLI;
                        if (funct7 != 7'b0000000) legal = 1'b0;
                    end
                    3'b101: begin
                        dec.imm = imm_sh;
                        if (funct7 == 7'b0000000)      dec.op = `SRLI;
                        else if (funct7 == 7'b0100000) dec.op = `SRAI;
                        else                           legal  = 1'b0;
                    end
                endcase
            end
            OPC_OP: begin
                dec.rd      = rd_f;
                dec.rs1     = rs1_f;
                dec.rs2     = rs2_f;
                dec.use_rs1 = 1'b1;
                dec.use_rs2 = 1'b1;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000: dec.op = `ADD;
                        3'b001: dec.op = `SLL;
                        3'b010: dec.op = `SLT;
                        3'b011: dec.op = `SLTU;
                        3'b100: dec.op = `XOR;
                        3'b101: dec.op = `SRL;
                        3'b110: dec.op = `OR;
                        3'b111: dec.op = `AND;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec.op = `SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec.op = `SRA;
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec         = '0;
            dec.pc      = in_pc;
            dec.illegal = 1'b1;
        end
    end

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Next-state of the FIFO: flush empties it, otherwise push at tail and pop at head.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (accept) begin
                mem_d[tail_q] = dec;
                tail_d        = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset also clears storage so an empty queue never shows X.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_e      = mem_q[head_q];
    assign out_pc      = head_e.pc;
    assign out_op      = head_e.op;
    assign out_rd      = head_e.rd;
    assign out_rs1     = head_e.rs1;
    assign out_rs2     = head_e.rs2;
    assign out_imm     = head_e.imm;
    assign out_use_rs1 = head_e.use_rs1;
    assign out_use_rs2 = head_e.use_rs2;
    assign out_is_sl   = head_e.is_sl;
    assign out_is_br   = head_e.is_br;
    assign out_illegal = head_e.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: table vectors, directed corner sequences and a random
// stream checked against a queue-based reference model of decode_queue.

`ifndef OpcodeLength
`define OpcodeLength 5
`define NOP   6'd0
`define LUI   6'd1
`define AUIPC 6'd2
`define JAL   6'd3
`define JALR  6'd4
`define BEQ   6'd5
`define BNE   6'd6
`define BLT   6'd7
`define BGE   6'd8
`define BLTU  6'd9
`define BGEU  6'd10
`define LB    6'd11
`define LH    6'd12
`define LW    6'd13
`define LBU   6'd14
`define LHU   6'd15
`define SB    6'd16
`define SH    6'd17
`define SW    6'd18
`define ADDI  6'd19
`define SLTI  6'd20
`define SLTIU 6'd21
`define XORI  6'd22
`define ORI   6'd23
`define ANDI  6'd24
`define SLLI  6'd25
`define SRLI  6'd26
`define SRAI  6'd27
`define ADD   6'd28
`define SUB   6'd29
`define SLL   6'd30
`define SLT   6'd31
`define SLTU  6'd32
`define XOR   6'd33
`define SRL   6'd34
`define SRA   6'd35
`define OR    6'd36
`define AND   6'd37
`endif

module tb_decode_queue;

    localparam int DEPTH = 2;
    localparam int OP_W  = `OpcodeLength + 1;

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]     in_pc, in_instr, out_pc, out_imm;
    logic [OP_W-1:0] out_op;
    logic [4:0]      out_rd, out_rs1, out_rs2;
    logic            out_use_rs1, out_use_rs2, out_is_sl, out_is_br, out_illegal;

    decode_queue #(.DEPTH(DEPTH), .XLEN(32), .PC_W(32), .REG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_use_rs1(out_use_rs1), .out_use_rs2(out_use_rs2),
        .out_is_sl(out_is_sl), .out_is_br(out_is_br), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     pc;
        logic [OP_W-1:0] op;
        logic [4:0]      rd, rs1, rs2;
        logic [31:0]     imm;
        logic [4:0]      flags;
    } uop_t;

    typedef struct {
        logic [31:0]     instr;
        logic [OP_W-1:0] op;
        logic [4:0]      rd, rs1, rs2;
        logic [31:0]     imm;
        logic [4:0]      flags;
    } vec_t;

    uop_t model_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    int br_tab[8] = '{`BEQ, `BNE, 0, 0, `BLT, `BGE, `BLTU, `BGEU};
    int ld_tab[8] = '{`LB, `LH, `LW, 0, `LBU, `LHU, 0, 0};
    int st_tab[8] = '{`SB, `SH, `SW, 0, 0, 0, 0, 0};
    int oi_tab[8] = '{`ADDI, 0, `SLTI, `SLTIU, `XORI, 0, `ORI, `ANDI};
    int r0_tab[8] = '{`ADD, `SLL, `SLT, `SLTU, `XOR, `SRL, `OR, `AND};
    logic [6:0] opc_list[9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_total++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    function automatic int sext(input int value, input int bits);
        return (value >= (1 << (bits - 1))) ? value - (1 << bits) : value;
    endfunction

    // Reference decode: classify by opcode, look the operation up, then apply the field rules.
    function automatic uop_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        uop_t u;
        int   f3 = int'(ins[14:12]);
        int   f7 = int'(ins[31:25]);
        int   op = 0;
        int   imm = 0;
        bit   wr = 0, r1 = 0, r2 = 0, sl = 0, br = 0;
        int   i_imm = sext(int'(ins[31:20]), 12);
        case (ins[6:0])
            7'h37: begin op = `LUI;   wr = 1; imm = int'(ins[31:12]) * 4096; end
            7'h17: begin op = `AUIPC; wr = 1; imm = int'(ins[31:12]) * 4096; end
            7'h6F: begin
                op = `JAL; wr = 1; br = 1;
                imm = sext(int'({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2, 21);
            end
            7'h67: begin op = (f3 == 0) ? `JALR : 0; wr = 1; r1 = 1; br = 1; imm = i_imm; end
            7'h63: begin
                op = br_tab[f3]; r1 = 1; r2 = 1; br = 1;
                imm = sext(int'({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2, 13);
            end
            7'h03: begin op = ld_tab[f3]; wr = 1; r1 = 1; sl = 1; imm = i_imm; end
            7'h23: begin
                op = st_tab[f3]; r1 = 1; r2 = 1; sl = 1;
                imm = sext(int'({ins[31:25], ins[11:7]}), 12);
            end
            7'h13: begin
                wr = 1; r1 = 1;
                if (f3 == 1 || f3 == 5) begin
                    imm = int'(ins[24:20]);
                    if (f3 == 1)     op = (f7 == 0) ? `SLLI : 0;
                    else if (f7 == 0) op = `SRLI;
                    else             op = (f7 == 32) ? `SRAI : 0;
                end else begin
                    op = oi_tab[f3]; imm = i_imm;
                end
            end
            7'h33: begin
                wr = 1; r1 = 1; r2 = 1;
                if (f7 == 0)                 op = r0_tab[f3];
                else if (f7 == 32 && f3 == 0) op = `SUB;
                else if (f7 == 32 && f3 == 5) op = `SRA;
                else                         op = 0;
            end
            default: op = 0;
        endcase
        u.pc = pc;
        if (op == 0) begin
            u.op = '0; u.rd = '0; u.rs1 = '0; u.rs2 = '0; u.imm = '0; u.flags = 5'b00001;
        end else begin
            u.op    = OP_W'(op);
            u.rd    = wr ? ins[11:7]  : 5'd0;
            u.rs1   = r1 ? ins[19:15] : 5'd0;
            u.rs2   = r2 ? ins[24:20] : 5'd0;
            u.imm   = 32'(imm);
            u.flags = {r1, r2, sl, br, 1'b0};
        end
        return u;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom();
        int          k = $urandom_range(0, 9);
        if (k < 9) w[6:0] = opc_list[k];
        if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h20;
        return w;
    endfunction

    task automatic compareModel();
        uop_t h;
        checkOutput("in_ready", 32'(in_ready), 32'(model_q.size() != DEPTH));
        checkOutput("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
        if (model_q.size() != 0) begin
            h = model_q[0];
            checkOutput("head_pc", out_pc, h.pc);
            checkOutput("head_op", 32'(out_op), 32'(h.op));
            checkOutput("head_regs", {17'd0, out_rd, out_rs1, out_rs2}, {17'd0, h.rd, h.rs1, h.rs2});
            checkOutput("head_imm", out_imm, h.imm);
            checkOutput("head_flags",
                        32'({out_use_rs1, out_use_rs2, out_is_sl, out_is_br, out_illegal}),
                        32'(h.flags));
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, compare just after it.
    task automatic applyStimulus(input logic r, input logic f, input logic v,
                                 input logic [31:0] pc, input logic [31:0] ins, input logic rdy);
        bit acc, pp;
        rst = r; flush = f; in_valid = v; in_pc = pc; in_instr = ins; out_ready = rdy;
        acc = v && (model_q.size() != DEPTH);
        pp  = rdy && (model_q.size() != 0);
        @(posedge clk);
        if (r || f) begin
            model_q.delete();
        end else begin
            if (pp) void'(model_q.pop_front());
            if (acc) model_q.push_back(ref_decode(ins, pc));
        end
        #1;
        compareModel();
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{32'hFFF00093, `ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 5'b10000};
        vecs[1]  = '{32'h123452B7, `LUI,  5'd5, 5'd0, 5'd0, 32'h12345000, 5'b00000};
        vecs[2]  = '{32'hFE208EE3, `BEQ,  5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 5'b11010};
        vecs[3]  = '{32'h00000000, `NOP,  5'd0, 5'd0, 5'd0, 32'h00000000, 5'b00001};
        vecs[4]  = '{32'h40001033, `NOP,  5'd0, 5'd0, 5'd0, 32'h00000000, 5'b00001};
        vecs[5]  = '{32'h0020A423, `SW,   5'd0, 5'd1, 5'd2, 32'h00000008, 5'b11100};
        vecs[6]  = '{32'hFF812183, `LW,   5'd3, 5'd2, 5'd0, 32'hFFFFFFF8, 5'b10100};
        vecs[7]  = '{32'h008000EF, `JAL,  5'd1, 5'd0, 5'd0, 32'h00000008, 5'b00010};
        vecs[8]  = '{32'h4032D213, `SRAI, 5'd4, 5'd5, 5'd0, 32'h00000003, 5'b10000};
        vecs[9]  = '{32'h40838333, `SUB,  5'd6, 5'd7, 5'd8, 32'h00000000, 5'b11000};
        vecs[10] = '{32'h00009067, `NOP,  5'd0, 5'd0, 5'd0, 32'h00000000, 5'b00001};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;

        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("no_x_after_reset",
                    32'($isunknown({out_pc, out_op, out_rd, out_rs1, out_rs2, out_imm,
                                    out_use_rs1, out_use_rs2, out_is_sl, out_is_br, out_illegal})),
                    32'd0);

        // Table vectors: push one, check the head against fixed expectations, pop it.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(0, 0, 1, 32'h100 + 32'(4 * i), vecs[i].instr, 0);
            checkOutput("vec_valid", 32'(out_valid), 32'd1);
            checkOutput("vec_pc", out_pc, 32'h100 + 32'(4 * i));
            checkOutput("vec_op", 32'(out_op), 32'(vecs[i].op));
            checkOutput("vec_regs", {17'd0, out_rd, out_rs1, out_rs2},
                        {17'd0, vecs[i].rd, vecs[i].rs1, vecs[i].rs2});
            checkOutput("vec_imm", out_imm, vecs[i].imm);
            checkOutput("vec_flags",
                        32'({out_use_rs1, out_use_rs2, out_is_sl, out_is_br, out_illegal}),
                        32'(vecs[i].flags));
            applyStimulus(0, 0, 0, 0, 0, 1);
        end

        // Full queue with the third instruction held, then drain in order.
        applyStimulus(0, 0, 1, 32'h200, vecs[0].instr, 0);
        applyStimulus(0, 0, 1, 32'h204, vecs[1].instr, 0);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        applyStimulus(0, 0, 1, 32'h208, vecs[2].instr, 0);
        checkOutput("held_head_a", out_pc, 32'h200);
        applyStimulus(0, 0, 1, 32'h208, vecs[2].instr, 1);
        checkOutput("order_b", out_pc, 32'h204);
        applyStimulus(0, 0, 1, 32'h208, vecs[2].instr, 1);
        checkOutput("order_c", out_pc, 32'h208);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("drained", 32'(out_valid), 32'd0);

        // Illegal entries keep FIFO order.
        applyStimulus(0, 0, 1, 32'h300, vecs[3].instr, 0);
        applyStimulus(0, 0, 1, 32'h304, vecs[4].instr, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("illegal_order", out_pc, 32'h304);
        applyStimulus(0, 0, 0, 0, 0, 1);

        // Flush with two queued and an instruction offered.
        applyStimulus(0, 0, 1, 32'h400, vecs[5].instr, 0);
        applyStimulus(0, 0, 1, 32'h404, vecs[6].instr, 0);
        applyStimulus(0, 1, 1, 32'h408, vecs[7].instr, 0);
        checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("flush_not_stored", 32'(out_valid), 32'd0);

        // Continuous stream with pointer wrap, then reset mid-stream.
        for (int i = 0; i < 10 * DEPTH + 3; i++) begin
            applyStimulus(0, 0, 1, 32'h1000 + 32'(4 * i), rand_instr(), 1);
        end
        applyStimulus(1, 0, 1, 32'h2000, rand_instr(), 1);
        checkOutput("rst_mid_stream", 32'(out_valid), 32'd0);

        // Random traffic with back-pressure and occasional flush.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(0, ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                          32'h3000 + 32'(4 * i), rand_instr(), ($urandom_range(0, 2) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
